// File: rtl/sensor_sched_pkg.sv
// -----------------------------------------------------------------------------
// sensor_sched_pkg
// Shared definitions for the sensor request scheduler:
//   - PC command codes (reads, continuous start/stop)
//   - response codes produced locally by the scheduler
//   - scheduler FSM state encoding
//   - small command-decoding helpers
// -----------------------------------------------------------------------------
package sensor_sched_pkg;

    // Commands received from the PC
    localparam logic [7:0] CMD_READ_HUM  = 8'h01;
    localparam logic [7:0] CMD_READ_TEMP = 8'h02;
    localparam logic [7:0] CMD_CONT_TEMP = 8'h03;
    localparam logic [7:0] CMD_CONT_HUM  = 8'h04;
    localparam logic [7:0] CMD_STOP_A    = 8'h05;
    localparam logic [7:0] CMD_STOP_B    = 8'h06;

    // Responses generated by the scheduler itself
    localparam logic [7:0] RESP_STOPPED  = 8'h0A;
    localparam logic [7:0] RESP_TIMEOUT  = 8'h1F;
    localparam logic [7:0] RESP_ZERO     = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ISSUE       = 3'd1,
        ST_WAIT_SENSOR = 3'd2,
        ST_SEND        = 3'd3,
        ST_TX          = 3'd4,
        ST_WAIT_TX     = 3'd5
    } sched_state_e;

    // True for either of the two stop-continuous commands
    function automatic logic is_stop_cmd(input logic [7:0] cmd);
        logic res;
        if ((cmd == CMD_STOP_A) || (cmd == CMD_STOP_B)) begin
            res = 1'b1;
        end else begin
            res = 1'b0;
        end
        return res;
    endfunction

    // True for either of the two start-continuous commands
    function automatic logic is_cont_start_cmd(input logic [7:0] cmd);
        logic res;
        if ((cmd == CMD_CONT_TEMP) || (cmd == CMD_CONT_HUM)) begin
            res = 1'b1;
        end else begin
            res = 1'b0;
        end
        return res;
    endfunction

    // Read command that a continuous-start command repeats
    function automatic logic [7:0] cont_read_cmd(input logic [7:0] cmd);
        logic [7:0] res;
        if (cmd == CMD_CONT_TEMP) begin
            res = CMD_READ_TEMP;
        end else begin
            res = CMD_READ_HUM;
        end
        return res;
    endfunction

endpackage

// File: rtl/sensor_request_scheduler_periodic_tick.sv
// -----------------------------------------------------------------------------
// periodic_tick
// Free-running period timer for continuous-monitoring mode. Counts while
// enabled, is held at zero while disabled, and restarts from zero on request.
// Emits a one-cycle registered tick each time the count wraps.
// Ports:
//   clock   - system clock
//   reset   - synchronous, active-high
//   enable  - count while high, clear while low
//   restart - force the count back to zero
//   tick    - one-cycle pulse, one cycle after the count reaches PERIOD-1
// -----------------------------------------------------------------------------
module periodic_tick #(
    parameter int PERIOD = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    localparam int              CW   = $clog2(PERIOD);
    localparam logic [CW-1:0]   LAST = CW'(PERIOD - 1);

    logic [CW-1:0] count_r;
    logic          tick_r;

    // Period counter with wrap-around tick generation
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= '0;
            tick_r  <= 1'b0;
        end else if (restart || !enable) begin
            count_r <= '0;
            tick_r  <= 1'b0;
        end else if (count_r == LAST) begin
            count_r <= '0;
            tick_r  <= 1'b1;
        end else begin
            count_r <= count_r + CW'(1);
            tick_r  <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/sensor_request_scheduler.sv
// -----------------------------------------------------------------------------
// sensor_request_scheduler
// Sequences sensor transactions between the UART receiver, the sensor block
// and the UART transmitter. Holds one pending PC request, issues it to the
// sensor, waits for the response (or a timeout) and hands two response bytes
// to the transmitter. Also runs continuous-monitoring mode, where a periodic
// timer re-issues a stored read; pending PC requests always go first.
// Ports:
//   clock, reset                      - clock, synchronous active-high reset
//   req_valid/req_command/req_address - request pulse and bytes from the PC
//   sensor_start/command/address      - transaction start pulse and bytes
//   sensor_done/resp_command/value    - response pulse and bytes from sensor
//   tx_start/tx_command/tx_value      - response handed to the transmitter
//   tx_busy                           - transmitter busy
//   busy                              - scheduler not idle
//   cont_active                       - continuous mode enabled
//   overflow                          - sticky, a request was dropped
// -----------------------------------------------------------------------------
module sensor_request_scheduler
    import sensor_sched_pkg::*;
#(
    parameter int PERIOD_CYCLES  = 50_000_000,
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [7:0] req_command,
    input  logic [7:0] req_address,
    output logic       sensor_start,
    output logic [7:0] sensor_command,
    output logic [7:0] sensor_address,
    input  logic       sensor_done,
    input  logic [7:0] sensor_resp_command,
    input  logic [7:0] sensor_resp_value,
    output logic       tx_start,
    output logic [7:0] tx_command,
    output logic [7:0] tx_value,
    input  logic       tx_busy,
    output logic       busy,
    output logic       cont_active,
    output logic       overflow
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    sched_state_e  state_r;
    sched_state_e  state_s;

    // Pending request buffer
    logic          pend_valid_r;
    logic [7:0]    pend_cmd_r;
    logic [7:0]    pend_addr_r;

    // Continuous-mode context
    logic          cont_active_r;
    logic          cont_due_r;
    logic [7:0]    cont_cmd_r;
    logic [7:0]    cont_addr_r;

    logic [TW-1:0] tmo_cnt_r;
    logic [7:0]    resp_cmd_r;
    logic [7:0]    resp_val_r;
    logic          wait_first_r;

    // Registered outputs
    logic          sensor_start_r;
    logic [7:0]    sensor_cmd_r;
    logic [7:0]    sensor_addr_r;
    logic          tx_start_r;
    logic [7:0]    tx_cmd_r;
    logic [7:0]    tx_val_r;
    logic          busy_r;
    logic          overflow_r;

    // FSM control strobes
    logic          consume_s;
    logic          issue_s;
    logic [7:0]    issue_cmd_s;
    logic [7:0]    issue_addr_s;
    logic          cont_start_s;
    logic          cont_stop_s;
    logic          serve_due_s;
    logic          resp_load_s;
    logic [7:0]    resp_cmd_s;
    logic [7:0]    resp_val_s;
    logic          tick_s;
    logic          accept_s;

    periodic_tick #(
        .PERIOD (PERIOD_CYCLES)
    ) u_period (
        .clock   (clock),
        .reset   (reset),
        .enable  (cont_active_r),
        .restart (cont_start_s),
        .tick    (tick_s)
    );

    // A new request fits if the slot is empty or is being emptied this cycle
    assign accept_s = req_valid && (!pend_valid_r || consume_s);

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state and control strobes
    always_comb begin
        state_s      = state_r;
        consume_s    = 1'b0;
        issue_s      = 1'b0;
        issue_cmd_s  = 8'h00;
        issue_addr_s = 8'h00;
        cont_start_s = 1'b0;
        cont_stop_s  = 1'b0;
        serve_due_s  = 1'b0;
        resp_load_s  = 1'b0;
        resp_cmd_s   = RESP_ZERO;
        resp_val_s   = RESP_ZERO;
        case (state_r)
            ST_IDLE: begin
                if (pend_valid_r) begin
                    consume_s = 1'b1;
                    if (is_stop_cmd(pend_cmd_r)) begin
                        // Stop is answered locally, no sensor access
                        cont_stop_s = 1'b1;
                        resp_load_s = 1'b1;
                        resp_cmd_s  = RESP_STOPPED;
                        resp_val_s  = RESP_ZERO;
                        state_s     = ST_SEND;
                    end else if (is_cont_start_cmd(pend_cmd_r)) begin
                        cont_start_s = 1'b1;
                        issue_s      = 1'b1;
                        issue_cmd_s  = cont_read_cmd(pend_cmd_r);
                        issue_addr_s = pend_addr_r;
                        state_s      = ST_ISSUE;
                    end else begin
                        issue_s      = 1'b1;
                        issue_cmd_s  = pend_cmd_r;
                        issue_addr_s = pend_addr_r;
                        state_s      = ST_ISSUE;
                    end
                end else if (cont_due_r) begin
                    serve_due_s  = 1'b1;
                    issue_s      = 1'b1;
                    issue_cmd_s  = cont_cmd_r;
                    issue_addr_s = cont_addr_r;
                    state_s      = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT_SENSOR;
            end
            ST_WAIT_SENSOR: begin
                // A response arriving on the timeout cycle still wins
                if (sensor_done) begin
                    resp_load_s = 1'b1;
                    resp_cmd_s  = sensor_resp_command;
                    resp_val_s  = sensor_resp_value;
                    state_s     = ST_SEND;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    resp_load_s = 1'b1;
                    resp_cmd_s  = RESP_TIMEOUT;
                    resp_val_s  = RESP_ZERO;
                    state_s     = ST_SEND;
                end else begin
                    state_s = ST_WAIT_SENSOR;
                end
            end
            ST_SEND: begin
                if (tx_busy) begin
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_TX;
                end
            end
            ST_TX: begin
                state_s = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                // The transmitter may not raise tx_busy until a cycle after tx_start
                if (wait_first_r || tx_busy) begin
                    state_s = ST_WAIT_TX;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Pending request buffer and sticky overflow flag
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_valid_r <= 1'b0;
            pend_cmd_r   <= 8'h00;
            pend_addr_r  <= 8'h00;
            overflow_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                pend_valid_r <= 1'b1;
                pend_cmd_r   <= req_command;
                pend_addr_r  <= req_address;
            end else if (consume_s) begin
                pend_valid_r <= 1'b0;
            end else begin
                pend_valid_r <= pend_valid_r;
            end
            if (req_valid && !accept_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Continuous-mode context and due flag
    always_ff @(posedge clock) begin
        if (reset) begin
            cont_active_r <= 1'b0;
            cont_due_r    <= 1'b0;
            cont_cmd_r    <= 8'h00;
            cont_addr_r   <= 8'h00;
        end else if (cont_start_s) begin
            cont_active_r <= 1'b1;
            cont_due_r    <= 1'b0;
            cont_cmd_r    <= cont_read_cmd(pend_cmd_r);
            cont_addr_r   <= pend_addr_r;
        end else if (cont_stop_s) begin
            cont_active_r <= 1'b0;
            cont_due_r    <= 1'b0;
        end else if (serve_due_s) begin
            cont_due_r    <= 1'b0;
        end else if (tick_s && cont_active_r) begin
            // Gating on cont_active_r drops a tick that lands just after a stop
            cont_due_r    <= 1'b1;
        end else begin
            cont_due_r    <= cont_due_r;
        end
    end

    // Sensor timeout counter, running only while waiting for the sensor
    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt_r <= '0;
        end else if (state_r == ST_WAIT_SENSOR) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
        end else begin
            tmo_cnt_r <= '0;
        end
    end

    // Response latch and first-cycle marker for WAIT_TX
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_cmd_r   <= 8'h00;
            resp_val_r   <= 8'h00;
            wait_first_r <= 1'b0;
        end else begin
            if (resp_load_s) begin
                resp_cmd_r <= resp_cmd_s;
                resp_val_r <= resp_val_s;
            end else begin
                resp_cmd_r <= resp_cmd_r;
                resp_val_r <= resp_val_r;
            end
            wait_first_r <= (state_r == ST_TX);
        end
    end

    // Output registers, driven from the next state so pulses align with ISSUE/TX
    always_ff @(posedge clock) begin
        if (reset) begin
            sensor_start_r <= 1'b0;
            sensor_cmd_r   <= 8'h00;
            sensor_addr_r  <= 8'h00;
            tx_start_r     <= 1'b0;
            tx_cmd_r       <= 8'h00;
            tx_val_r       <= 8'h00;
            busy_r         <= 1'b0;
        end else begin
            sensor_start_r <= issue_s;
            if (issue_s) begin
                sensor_cmd_r  <= issue_cmd_s;
                sensor_addr_r <= issue_addr_s;
            end else begin
                sensor_cmd_r  <= sensor_cmd_r;
                sensor_addr_r <= sensor_addr_r;
            end
            tx_start_r <= (state_s == ST_TX);
            if (state_s == ST_TX) begin
                tx_cmd_r <= resp_cmd_r;
                tx_val_r <= resp_val_r;
            end else begin
                tx_cmd_r <= tx_cmd_r;
                tx_val_r <= tx_val_r;
            end
            busy_r <= (state_s != ST_IDLE);
        end
    end

    assign sensor_start   = sensor_start_r;
    assign sensor_command = sensor_cmd_r;
    assign sensor_address = sensor_addr_r;
    assign tx_start       = tx_start_r;
    assign tx_command     = tx_cmd_r;
    assign tx_value       = tx_val_r;
    assign busy           = busy_r;
    assign cont_active    = cont_active_r;
    assign overflow       = overflow_r;

endmodule

// File: tb/tb_sensor_request_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sensor_request_scheduler
// Directed bench for sensor_request_scheduler with PERIOD_CYCLES=100 and
// TIMEOUT_CYCLES=20. Inputs change #1 after a rising edge and outputs are
// sampled at the same point, so each step() lands in the next clock cycle.
// -----------------------------------------------------------------------------
module tb_sensor_request_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [7:0] req_command;
    logic [7:0] req_address;
    logic       sensor_start;
    logic [7:0] sensor_command;
    logic [7:0] sensor_address;
    logic       sensor_done;
    logic [7:0] sensor_resp_command;
    logic [7:0] sensor_resp_value;
    logic       tx_start;
    logic [7:0] tx_command;
    logic [7:0] tx_value;
    logic       tx_busy;
    logic       busy;
    logic       cont_active;
    logic       overflow;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int t0, t1, t2, ta;
    logic flag;

    sensor_request_scheduler #(
        .PERIOD_CYCLES  (100),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_command         (req_command),
        .req_address         (req_address),
        .sensor_start        (sensor_start),
        .sensor_command      (sensor_command),
        .sensor_address      (sensor_address),
        .sensor_done         (sensor_done),
        .sensor_resp_command (sensor_resp_command),
        .sensor_resp_value   (sensor_resp_value),
        .tx_start            (tx_start),
        .tx_command          (tx_command),
        .tx_value            (tx_value),
        .tx_busy             (tx_busy),
        .busy                (busy),
        .cont_active         (cont_active),
        .overflow            (overflow)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [7:0] c, input logic [7:0] a);
        req_valid   = 1'b1;
        req_command = c;
        req_address = a;
        step();
        req_valid   = 1'b0;
    endtask

    // Call in the sensor_start cycle; answers in the first WAIT_SENSOR cycle
    task automatic reply(input logic [7:0] c, input logic [7:0] v);
        step();
        sensor_done         = 1'b1;
        sensor_resp_command = c;
        sensor_resp_value   = v;
        step();
        sensor_done         = 1'b0;
        sensor_resp_command = 8'h00;
        sensor_resp_value   = 8'h00;
    endtask

    task automatic wait_start(input string tag, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (sensor_start === 1'b1) begin
                at = cyc;
                break;
            end
            step();
        end
        chk(tag, (at >= 0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_tx(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (tx_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_command = 8'h00; req_address = 8'h00;
        sensor_done = 1'b0; sensor_resp_command = 8'h00; sensor_resp_value = 8'h00;
        tx_busy = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        chk("reset_ctl", {27'd0, sensor_start, tx_start, busy, cont_active, overflow}, 32'd0);
        chk("reset_data", {sensor_command, sensor_address, tx_command, tx_value}, 32'd0);

        // Single read: request in cycle 0, sensor_start in cycle 2
        step();
        req_valid = 1'b1; req_command = 8'h02; req_address = 8'h01;
        step(); req_valid = 1'b0;
        chk("t1_no_start_c1", {31'd0, sensor_start}, 32'd0);
        step();
        chk("t1_start_c2", {31'd0, sensor_start}, 32'd1);
        chk("t1_sensor_bytes", {16'd0, sensor_command, sensor_address}, 32'h0201);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        step();
        chk("t1_start_pulse", {31'd0, sensor_start}, 32'd0);
        sensor_done = 1'b1; sensor_resp_command = 8'h09; sensor_resp_value = 8'h19;
        step();
        sensor_done = 1'b0;
        chk("t1_no_tx_c4", {31'd0, tx_start}, 32'd0);
        step();
        chk("t1_tx_start", {31'd0, tx_start}, 32'd1);
        chk("t1_tx_bytes", {16'd0, tx_command, tx_value}, 32'h0919);
        tx_busy = 1'b1;
        repeat (3) step();
        chk("t1_busy_hold", {31'd0, busy}, 32'd1);
        tx_busy = 1'b0;
        step();
        chk("t1_idle", {31'd0, busy}, 32'd0);
        chk("t1_tx_held", {16'd0, tx_command, tx_value}, 32'h0919);

        // Timeout: counter reaches 19 on the 20th cycle after sensor_start,
        // then SEND and TX add two cycles
        step();
        send_req(8'h01, 8'h05);
        wait_start("t2_start", 5, t0);
        flag = 1'b0;
        for (int i = 0; i < 21; i++) begin
            step();
            if (tx_start === 1'b1) flag = 1'b1;
        end
        chk("t2_no_early_tx", {31'd0, flag}, 32'd0);
        step();
        chk("t2_tx_at_22", {31'd0, tx_start}, 32'd1);
        chk("t2_tx_bytes", {16'd0, tx_command, tx_value}, 32'h1F00);
        repeat (3) step();
        chk("t2_idle", {31'd0, busy}, 32'd0);

        // sensor_done on the timeout cycle wins; SEND holds while tx_busy
        step();
        send_req(8'h02, 8'h03);
        wait_start("t2b_start", 5, t0);
        repeat (20) step();
        sensor_done = 1'b1; sensor_resp_command = 8'h09; sensor_resp_value = 8'h55;
        tx_busy = 1'b1;
        step();
        sensor_done = 1'b0;
        step();
        chk("t2b_hold_busy", {31'd0, tx_start}, 32'd0);
        tx_busy = 1'b0;
        step();
        chk("t2b_tx_start", {31'd0, tx_start}, 32'd1);
        chk("t2b_tx_bytes", {16'd0, tx_command, tx_value}, 32'h0955);
        repeat (3) step();

        // Continuous temperature: immediate read, then periodic reads, then stop
        step();
        send_req(8'h03, 8'h01);
        wait_start("t3_imm", 5, t0);
        chk("t3_imm_bytes", {16'd0, sensor_command, sensor_address}, 32'h0201);
        chk("t3_cont_on", {31'd0, cont_active}, 32'd1);
        reply(8'h02, 8'h33);
        wait_tx("t3_imm_tx", 5);
        chk("t3_imm_tx_bytes", {16'd0, tx_command, tx_value}, 32'h0233);
        repeat (3) step();
        wait_start("t3_per1", 200, t1);
        chk("t3_first_gap", t1 - t0, 32'd102);
        chk("t3_per1_bytes", {16'd0, sensor_command, sensor_address}, 32'h0201);
        reply(8'h02, 8'h34);
        wait_tx("t3_per1_tx", 5);
        repeat (3) step();
        wait_start("t3_per2", 200, t2);
        chk("t3_period", t2 - t1, 32'd100);
        reply(8'h02, 8'h35);
        wait_tx("t3_per2_tx", 5);
        repeat (3) step();
        send_req(8'h05, 8'h00);
        step();
        chk("t3_cont_off", {31'd0, cont_active}, 32'd0);
        step();
        chk("t3_stop_tx", {31'd0, tx_start}, 32'd1);
        chk("t3_stop_bytes", {16'd0, tx_command, tx_value}, 32'h0A00);
        flag = 1'b0;
        for (int i = 0; i < 250; i++) begin
            step();
            if (sensor_start === 1'b1) flag = 1'b1;
        end
        chk("t3_no_reads_after_stop", {31'd0, flag}, 32'd0);

        // Priority: PC request and cont_due pending together, PC goes first
        step();
        send_req(8'h04, 8'h07);
        wait_start("t4_imm", 5, t0);
        chk("t4_imm_bytes", {16'd0, sensor_command, sensor_address}, 32'h0107);
        reply(8'h01, 8'h40);
        wait_tx("t4_imm_tx", 5);
        while (cyc < t0 + 90) step();
        send_req(8'h02, 8'h0A);
        wait_start("t4_pc1", 5, ta);
        chk("t4_pc1_time", ta - t0, 32'd92);
        chk("t4_pc1_bytes", {16'd0, sensor_command, sensor_address}, 32'h020A);
        while (cyc < t0 + 100) step();
        send_req(8'h01, 8'h0B);
        while (cyc < t0 + 105) step();
        sensor_done = 1'b1; sensor_resp_command = 8'h02; sensor_resp_value = 8'h41;
        step();
        sensor_done = 1'b0;
        wait_tx("t4_pc1_tx", 5);
        chk("t4_pc1_tx_bytes", {16'd0, tx_command, tx_value}, 32'h0241);
        repeat (3) step();
        wait_start("t4_pc2", 5, ta);
        chk("t4_pc_first", {16'd0, sensor_command, sensor_address}, 32'h010B);
        reply(8'h01, 8'h42);
        wait_tx("t4_pc2_tx", 5);
        repeat (3) step();
        wait_start("t4_cont", 5, ta);
        chk("t4_cont_after", {16'd0, sensor_command, sensor_address}, 32'h0107);
        reply(8'h01, 8'h43);
        wait_tx("t4_cont_tx", 5);
        repeat (3) step();
        send_req(8'h06, 8'h00);
        step();
        step();
        chk("t4_stop_tx", {31'd0, tx_start}, 32'd1);
        chk("t4_stop_bytes", {16'd0, tx_command, tx_value}, 32'h0A00);
        repeat (3) step();

        // Overflow: one request buffered while busy, the next two dropped
        step();
        send_req(8'h02, 8'h21);
        wait_start("t5_a", 5, ta);
        chk("t5_no_ovf", {31'd0, overflow}, 32'd0);
        step(); step();
        send_req(8'h01, 8'h22);
        chk("t5_buffered_no_ovf", {31'd0, overflow}, 32'd0);
        send_req(8'h02, 8'h23);
        chk("t5_ovf_set", {31'd0, overflow}, 32'd1);
        send_req(8'h01, 8'h24);
        sensor_done = 1'b1; sensor_resp_command = 8'h02; sensor_resp_value = 8'h50;
        step();
        sensor_done = 1'b0;
        wait_tx("t5_a_tx", 5);
        chk("t5_a_tx_bytes", {16'd0, tx_command, tx_value}, 32'h0250);
        wait_start("t5_b", 10, ta);
        chk("t5_b_bytes", {16'd0, sensor_command, sensor_address}, 32'h0122);
        reply(8'h01, 8'h51);
        wait_tx("t5_b_tx", 5);
        repeat (3) step();
        flag = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (sensor_start === 1'b1) flag = 1'b1;
        end
        chk("t5_dropped_not_run", {31'd0, flag}, 32'd0);
        chk("t5_ovf_sticky", {31'd0, overflow}, 32'd1);

        // Reset during WAIT_SENSOR with continuous mode active
        step();
        send_req(8'h03, 8'h01);
        wait_start("t6_start", 5, ta);
        step();
        chk("t6_cont_before", {31'd0, cont_active}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_ctl", {27'd0, sensor_start, tx_start, busy, cont_active, overflow}, 32'd0);
        chk("t6_data", {sensor_command, sensor_address, tx_command, tx_value}, 32'd0);
        sensor_done = 1'b1; sensor_resp_command = 8'h02; sensor_resp_value = 8'h77;
        step();
        sensor_done = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if ((tx_start === 1'b1) || (sensor_start === 1'b1) || (busy === 1'b1)) flag = 1'b1;
        end
        chk("t6_quiet_after_reset", {31'd0, flag}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
